// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters in bursts of up to MAX_BURST words.
// Define FIFO_WR_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int OWN_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    input  logic                      fifo_wr_full,
    output logic [OWN_W-1:0]          owner,
    output logic                      busy,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [15:0]               stall_cnt,
`endif
    output logic                      dbg_state,
    output logic [7:0]                dbg_burst_cnt,
    output logic [OWN_W-1:0]          dbg_rr_ptr
);

    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   w_owner_nx;
    logic [OWN_W-1:0]   r_rr_ptr;
    logic [OWN_W-1:0]   w_rr_ptr_nx;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [CNT_W-1:0]   w_burst_cnt_nx;

    logic               w_any;
    logic [OWN_W-1:0]   w_pick;
    logic               w_owner_req;
    logic               w_accept;
    logic               w_last;
    logic [OWN_W-1:0]   w_owner_inc;

    // Handshake: req[i] is "valid" and is held with its word stable until gnt[i];
    // gnt[i] is the consume strobe, the word is written to the FIFO in that same cycle.

    // First requester at or after r_rr_ptr, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_any  = 1'b1;
                w_pick = OWN_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_owner_req = req[r_owner];
    assign w_accept    = (r_state == S_BURST) && w_owner_req && !fifo_wr_full;
    assign w_last      = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_owner_inc = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);

    always_comb begin
        w_state_nx     = r_state;
        w_owner_nx     = r_owner;
        w_rr_ptr_nx    = r_rr_ptr;
        w_burst_cnt_nx = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nx     = S_BURST;
                    w_owner_nx     = w_pick;
                    w_burst_cnt_nx = '0;
                end
            end
            S_BURST: begin
                if (w_accept && w_last) begin
                    w_state_nx  = S_IDLE;
                    w_rr_ptr_nx = w_owner_inc;
                end else if (!w_owner_req) begin
                    w_state_nx  = S_IDLE;
                    w_rr_ptr_nx = w_owner_inc;
                end else if (w_accept) begin
                    w_burst_cnt_nx = r_burst_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Write-side outputs are combinational and gated by reset so a mid-burst reset drops them at once.
    always_comb begin
        gnt          = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        if (reset) begin
            fifo_wr_en = w_accept;
            if (w_accept) begin
                gnt[r_owner] = 1'b1;
            end
            if (r_state == S_BURST) begin
                fifo_data_in = req_data[int'(r_owner) * DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_owner     <= w_owner_nx;
            r_rr_ptr    <= w_rr_ptr_nx;
            r_burst_cnt <= w_burst_cnt_nx;
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_BURST) && w_owner_req && fifo_wr_full &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign owner         = r_owner;
    assign busy          = (r_state == S_BURST);
    assign dbg_state     = r_state;
    assign dbg_burst_cnt = r_burst_cnt;
    assign dbg_rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: requesters are word queues, a spec-level model predicts every cycle.
// Builds with or without FIFO_WR_ARB_STALL_CNT_EN.
module tb_fifo_wr_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;
    localparam int OW = 2;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_data_in;
    logic             fifo_wr_full;
    logic [OW-1:0]    owner;
    logic             busy;
    logic             dbg_state;
    logic [7:0]       dbg_burst_cnt;
    logic [OW-1:0]    dbg_rr_ptr;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    fifo_wr_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .fifo_wr_full (fifo_wr_full),
        .owner        (owner),
        .busy         (busy),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .dbg_state    (dbg_state),
        .dbg_burst_cnt(dbg_burst_cnt),
        .dbg_rr_ptr   (dbg_rr_ptr)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int writes = 0;

    logic [DW-1:0] src_q[NR][$];
    logic [DW-1:0] exp_q[$];
    int            gnt_log[$];

    // Reference model state, in spec terms.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    int m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NR; k++) begin
            if (req[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i] = (src_q[i].size() != 0);
            if (req[i]) req_data[i*DW +: DW] = src_q[i][0];
            else        req_data[i*DW +: DW] = DW'($urandom_range(0, 255));
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_stall = 0;
    endtask

    // Called just after a rising edge with inputs driven; checks mid-cycle, then advances.
    task automatic cycle();
        logic [NR-1:0] e_gnt;
        logic [DW-1:0] e_data;
        bit            acc;
        int            gi;
        int            p;
        @(negedge clk);
        acc   = reset && m_busy && req[m_owner] && !fifo_wr_full;
        gi    = m_owner;
        e_gnt = '0;
        if (acc) e_gnt[m_owner] = 1'b1;
        e_data = (reset && m_busy) ? req_data[m_owner*DW +: DW] : '0;
        if (acc) exp_q.push_back(src_q[m_owner][0]);

        chk("gnt",       32'(gnt),           32'(e_gnt));
        chk("wr_en",     32'(fifo_wr_en),    32'(acc));
        chk("data",      32'(fifo_data_in),  32'(e_data));
        chk("busy",      32'(busy),          32'(m_busy));
        chk("owner",     32'(owner),         32'(m_owner));
        chk("burst_cnt", 32'(dbg_burst_cnt), 32'(m_cnt));
        chk("rr_ptr",    32'(dbg_rr_ptr),    32'(m_ptr));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt),     32'(m_stall));
`endif
        if (fifo_wr_en === 1'b1) begin
            gnt_log.push_back(int'(owner));
            if (exp_q.size() != 0) chk("sb_word", 32'(fifo_data_in), 32'(exp_q.pop_front()));
        end

        if (!reset) begin
            model_reset();
        end else if (!m_busy) begin
            p = pick();
            if (p >= 0) begin
                m_busy  = 1'b1;
                m_owner = p;
                m_cnt   = 0;
            end
        end else begin
            if (req[m_owner] && fifo_wr_full && m_stall < 65535) m_stall++;
            if (acc && m_cnt == MB - 1) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NR;
            end else if (!req[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NR;
            end else if (acc) begin
                m_cnt++;
            end
        end

        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q[gi].pop_front());
            writes++;
        end
        drive();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int w0;
        int s0;
        int exp_owner[$];

        reset        = 1'b0;
        req          = '0;
        req_data     = '0;
        fifo_wr_full = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        drive();
        cycle();
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_owner", 32'(owner),        32'd0);
        chk("rst_data",  32'(fifo_data_in), 32'd0);
        reset = 1'b1;
        repeat (2) cycle();

        // Single requester, six words: 4-word burst, idle, then the last two.
        w0 = writes;
        for (int v = 'h10; v <= 'h15; v++) src_q[0].push_back(DW'(v));
        drive();
        repeat (10) cycle();
        chk("t2_writes", 32'(writes - w0), 32'd6);

        // All four requesting from a fresh reset: owners 0,1,2,3,0, four words each.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        gnt_log.delete();
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < MB; j++) src_q[i].push_back(DW'(i * 16 + j));
        for (int j = 0; j < MB; j++) src_q[0].push_back(DW'(8'hA0 + j));
        drive();
        repeat (28) cycle();
        exp_owner = '{0, 1, 2, 3, 0};
        chk("t3_count", 32'(gnt_log.size()), 32'd20);
        for (int b = 0; b < 5; b++)
            for (int j = 0; j < MB; j++)
                if (b * MB + j < gnt_log.size())
                    chk("t3_owner_seq", 32'(gnt_log[b*MB + j]), 32'(exp_owner[b]));

        // Owner 2 stalled by full for 5 cycles mid-burst.
        w0 = writes;
        s0 = m_stall;
        for (int j = 0; j < MB; j++) src_q[2].push_back(DW'(8'hC0 + j));
        drive();
        repeat (3) cycle();
        chk("t4_pre_writes", 32'(writes - w0), 32'd2);
        fifo_wr_full = 1'b1;
        repeat (5) cycle();
        chk("t4_frozen_cnt", 32'(dbg_burst_cnt), 32'd2);
        fifo_wr_full = 1'b0;
        repeat (4) cycle();
        chk("t4_writes", 32'(writes - w0), 32'd4);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        chk("t4_stall_cnt", 32'(stall_cnt), 32'(s0 + 5));
`else
        s0 = s0 + 0;
`endif

        // Owner 1 drops req after two words; rr_ptr moves to 2, so 0 wins over 1.
        src_q[1].push_back(8'h51);
        src_q[1].push_back(8'h52);
        drive();
        repeat (4) cycle();
        chk("t5_busy",  32'(busy),       32'd0);
        chk("t5_rrptr", 32'(dbg_rr_ptr), 32'd2);
        src_q[0].push_back(8'h61);
        src_q[0].push_back(8'h62);
        src_q[1].push_back(8'h71);
        src_q[1].push_back(8'h72);
        drive();
        cycle();
        chk("t5_owner", 32'(owner), 32'd0);
        repeat (10) cycle();

        // Reset asserted mid-burst.
        for (int j = 0; j < MB; j++) src_q[3].push_back(DW'(8'hE0 + j));
        drive();
        repeat (2) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("t6_busy",  32'(busy),  32'd0);
        chk("t6_owner", 32'(owner), 32'd0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        drive();
        repeat (2) cycle();

        // Random traffic, full and occasional reset.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NR; i++)
                if (src_q[i].size() < 3 && $urandom_range(0, 2) == 0)
                    src_q[i].push_back(DW'($urandom_range(0, 255)));
            fifo_wr_full = ($urandom_range(0, 3) == 0);
            reset        = ($urandom_range(0, 149) != 0);
            drive();
            cycle();
        end

        reset        = 1'b1;
        fifo_wr_full = 1'b0;
        drive();
        repeat (60) cycle();
        chk("drain_sb", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NR; i++) chk("drain_src", 32'(src_q[i].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
